// File: rtl/bpm_pkg.sv
// Shared types and constants for the BPM estimator.
package bpm_pkg;

    typedef enum logic [1:0] {
        WAIT_FIRST,
        PRIME,
        TRACK
    } state_e;

    localparam int unsigned MS_PER_MIN = 60000;
    localparam int unsigned DIV_W      = 16;

    function automatic int unsigned calc_timeout_ms(input int unsigned min_bpm);
        return MS_PER_MIN / min_bpm;
    endfunction

    function automatic int unsigned calc_refractory_ms(input int unsigned max_bpm);
        return MS_PER_MIN / max_bpm;
    endfunction

endpackage

// File: rtl/bpm_estimator_if.sv
// Beat input and BPM result bundle between the estimator and the brightness filter.
interface bpm_estimator_if #(
    parameter int unsigned BPM_W = 8
);
    logic             beat_in;
    logic [BPM_W-1:0] BPM_estimate;
    logic             bpm_valid;
    logic             beat_pulse;
    logic             timeout;

    modport master (
        input  beat_in,
        output BPM_estimate, bpm_valid, beat_pulse, timeout
    );

    modport slave (
        output beat_in,
        input  BPM_estimate, bpm_valid, beat_pulse, timeout
    );
endinterface

// File: rtl/bpm_divider.sv
// 16-bit restoring divider: one load cycle, 16 iteration cycles, registered done strobe.
module bpm_divider
    import bpm_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             abort_i,
    input  logic             start_i,
    input  logic [DIV_W-1:0] dividend_i,
    input  logic [DIV_W-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [DIV_W-1:0] quotient_o
);
    localparam int unsigned CNT_W = $clog2(DIV_W + 1);

    logic [DIV_W-1:0] rem_q, quo_q, dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q, done_q;
    logic [DIV_W:0]   shifted_c, trial_c;

    // Bit DIV_W of the trial difference is set when the divisor does not fit.
    assign shifted_c = {rem_q, quo_q[DIV_W-1]};
    assign trial_c   = shifted_c - {1'b0, dvs_q};

    always_ff @(posedge clk) begin
        if (!reset) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (abort_i) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (busy_q) begin
                if (trial_c[DIV_W]) begin
                    rem_q <= shifted_c[DIV_W-1:0];
                    quo_q <= {quo_q[DIV_W-2:0], 1'b0};
                end else begin
                    rem_q <= trial_c[DIV_W-1:0];
                    quo_q <= {quo_q[DIV_W-2:0], 1'b1};
                end
                cnt_q <= cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end else if (start_i) begin
                rem_q  <= '0;
                quo_q  <= dividend_i;
                dvs_q  <= divisor_i;
                cnt_q  <= CNT_W'(DIV_W);
                busy_q <= 1'b1;
            end
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign quotient_o = quo_q;

endmodule

// File: rtl/bpm_estimator.sv
// Beat-interval BPM estimator feeding the brightness filter.
// Define BPM_AVG_EN to average the last AVG_DEPTH intervals; otherwise the latest interval is used.
module bpm_estimator
    import bpm_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned MIN_BPM   = 40,
    parameter int unsigned MAX_BPM   = 200,
    parameter int unsigned AVG_DEPTH = 4,
    parameter int unsigned BPM_W     = $clog2(MAX_BPM + 1)
) (
    input  logic            clk,
    input  logic            reset,
    bpm_estimator_if.master bpm_if
);
    localparam int unsigned TICK_CYC   = CLK_HZ / 1000;
    localparam int unsigned PSC_W      = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam int unsigned TIMEOUT_MS = calc_timeout_ms(MIN_BPM);
    localparam int unsigned REFRACT_MS = calc_refractory_ms(MAX_BPM);
    localparam int unsigned IV_W       = $clog2(TIMEOUT_MS + 1);

    if (AVG_DEPTH < 2 || (AVG_DEPTH & (AVG_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("AVG_DEPTH must be a power of 2 and at least 2");
    end

    state_e           state_q, state_d;
    logic [PSC_W-1:0] psc_q;
    logic [IV_W-1:0]  ival_q, avg_c;
    logic             beat_q;
    logic             ms_tick_c, edge_c, accept_c, tmo_c;
    logic [BPM_W-1:0] bpm_q, bpm_d;
    logic             valid_q, valid_d, pulse_q, pulse_d, tmo_q, tmo_d;
    logic             start_q, start_d, pend_q, pend_d;
    logic             div_busy, div_done;
    logic [DIV_W-1:0] div_quo, clamped_c;

    assign ms_tick_c = (psc_q == PSC_W'(TICK_CYC - 1));
    assign edge_c    = bpm_if.beat_in & ~beat_q;
    assign accept_c  = edge_c & ((state_q == WAIT_FIRST) | (ival_q >= IV_W'(REFRACT_MS)));
    // An accepted beat in the saturation cycle wins over the timeout.
    assign tmo_c     = (state_q != WAIT_FIRST) & (ival_q == IV_W'(TIMEOUT_MS)) & ~accept_c;

    always_ff @(posedge clk) begin
        if (!reset) begin
            psc_q  <= '0;
            ival_q <= '0;
            beat_q <= 1'b0;
        end else begin
            beat_q <= bpm_if.beat_in;
            if (accept_c) begin
                psc_q  <= '0;
                ival_q <= '0;
            end else begin
                psc_q <= ms_tick_c ? '0 : psc_q + PSC_W'(1);
                if (ms_tick_c && ival_q != IV_W'(TIMEOUT_MS))
                    ival_q <= ival_q + IV_W'(1);
            end
        end
    end

`ifdef BPM_AVG_EN
    localparam int unsigned AVG_SH = $clog2(AVG_DEPTH);
    localparam int unsigned SUM_W  = IV_W + AVG_SH;

    logic [IV_W-1:0]   ring_q [AVG_DEPTH];
    logic [AVG_SH-1:0] wptr_q;
    logic [SUM_W-1:0]  sum_q;

    // Priming fills every slot so the first average equals the first interval.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < AVG_DEPTH; i++) ring_q[i] <= '0;
            wptr_q <= '0;
            sum_q  <= '0;
        end else if (accept_c && state_q == PRIME) begin
            for (int i = 0; i < AVG_DEPTH; i++) ring_q[i] <= ival_q;
            wptr_q <= '0;
            sum_q  <= SUM_W'(ival_q) << AVG_SH;
        end else if (accept_c && state_q == TRACK) begin
            ring_q[wptr_q] <= ival_q;
            wptr_q         <= wptr_q + AVG_SH'(1);
            sum_q          <= sum_q + SUM_W'(ival_q) - SUM_W'(ring_q[wptr_q]);
        end
    end

    assign avg_c = IV_W'(sum_q >> AVG_SH);
`else
    logic [IV_W-1:0] last_q;

    always_ff @(posedge clk) begin
        if (!reset)
            last_q <= '0;
        else if (accept_c && state_q != WAIT_FIRST)
            last_q <= ival_q;
    end

    assign avg_c = last_q;
`endif

    bpm_divider u_div (
        .clk        (clk),
        .reset      (reset),
        .abort_i    (tmo_c),
        .start_i    (start_q),
        .dividend_i (DIV_W'(MS_PER_MIN)),
        .divisor_i  (DIV_W'(avg_c)),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quotient_o (div_quo)
    );

    assign clamped_c = (div_quo < DIV_W'(MIN_BPM)) ? DIV_W'(MIN_BPM) :
                       (div_quo > DIV_W'(MAX_BPM)) ? DIV_W'(MAX_BPM) : div_quo;

    always_comb begin
        state_d = state_q;
        bpm_d   = bpm_q;
        valid_d = valid_q;
        pulse_d = accept_c;
        tmo_d   = tmo_q;
        start_d = 1'b0;
        pend_d  = pend_q;
        if (div_done) begin
            bpm_d   = BPM_W'(clamped_c);
            valid_d = 1'b1;
            if (pend_q) begin
                start_d = 1'b1;
                pend_d  = 1'b0;
            end
        end
        unique case (state_q)
            WAIT_FIRST: begin
                if (accept_c) begin
                    state_d = PRIME;
                    tmo_d   = 1'b0;
                end
            end
            PRIME, TRACK: begin
                if (accept_c) begin
                    state_d = TRACK;
                    // Divider still owns the previous request: rerun once with the newest sum.
                    if (div_busy || start_q) pend_d  = 1'b1;
                    else                     start_d = 1'b1;
                end else if (tmo_c) begin
                    state_d = WAIT_FIRST;
                    tmo_d   = 1'b1;
                    bpm_d   = '0;
                    valid_d = 1'b0;
                    start_d = 1'b0;
                    pend_d  = 1'b0;
                end
            end
            default: state_d = WAIT_FIRST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= WAIT_FIRST;
            bpm_q   <= '0;
            valid_q <= 1'b0;
            pulse_q <= 1'b0;
            tmo_q   <= 1'b0;
            start_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bpm_q   <= bpm_d;
            valid_q <= valid_d;
            pulse_q <= pulse_d;
            tmo_q   <= tmo_d;
            start_q <= start_d;
            pend_q  <= pend_d;
        end
    end

    assign bpm_if.BPM_estimate = bpm_q;
    assign bpm_if.bpm_valid    = valid_q;
    assign bpm_if.beat_pulse   = pulse_q;
    assign bpm_if.timeout      = tmo_q;

endmodule

// File: tb/tb_bpm_estimator.sv
// Directed bench for bpm_estimator at CLK_HZ=4000 (4 clocks per ms), expectations for either BPM_AVG_EN setting.
module tb_bpm_estimator;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bpm_estimator_if #(.BPM_W(8)) bif ();

    bpm_estimator #(
        .CLK_HZ    (4000),
        .MIN_BPM   (40),
        .MAX_BPM   (200),
        .AVG_DEPTH (4),
        .BPM_W     (8)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bpm_if (bif)
    );

    typedef struct {
        int gap_ms;
        int exp_bpm;
    } vec_t;

    int   n_cmp = 0;
    int   n_err = 0;
    int   since = 0;
    int   p;
    int   npulse;
    int   prev;
    int   exp_low;
    vec_t vecs [6];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input int bpm, input int valid, input int tmo);
        check({tag, ".bpm"},     int'(bif.BPM_estimate), bpm);
        check({tag, ".valid"},   bif.bpm_valid ? 1 : 0,  valid);
        check({tag, ".timeout"}, bif.timeout ? 1 : 0,    tmo);
    endtask

    // since = negedges elapsed since the pulse cycle of the last reference beat
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            since++;
        end
    endtask

    task automatic beat_now(input bit mark, output int pulse);
        bif.beat_in = 1'b1;
        @(negedge clk);
        pulse = bif.beat_pulse ? 1 : 0;
        bif.beat_in = 1'b0;
        if (mark) since = 0;
        else      since++;
    endtask

    // Edge lands exactly ms*4+1 clocks after the previous reference edge, so interval_ms == ms.
    task automatic beat_gap(input int ms, output int pulse);
        idle(4 * ms - since);
        beat_now(1'b1, pulse);
    endtask

    initial begin
`ifdef BPM_AVG_EN
        vecs[0] = '{500, 120};
        vecs[1] = '{400, 126};
        vecs[2] = '{400, 133};
        vecs[3] = '{400, 141};
        vecs[4] = '{400, 150};
        vecs[5] = '{400, 150};
        exp_low = 100;
`else
        vecs[0] = '{500, 120};
        vecs[1] = '{400, 150};
        vecs[2] = '{400, 150};
        vecs[3] = '{400, 150};
        vecs[4] = '{400, 150};
        vecs[5] = '{400, 150};
        exp_low = 40;
`endif
        reset       = 1'b0;
        bif.beat_in = 1'b0;
        repeat (3) @(negedge clk);
        check_out("reset", 0, 0, 0);
        check("reset.pulse", bif.beat_pulse ? 1 : 0, 0);
        reset = 1'b1;
        idle(10);

        // First beat only starts timing.
        beat_now(1'b1, p);
        check("first.pulse", p, 1);
        idle(20);
        check_out("first", 0, 0, 0);

        // Priming beat: result appears exactly 18 cycles after the pulse.
        beat_gap(500, p);
        check("prime.pulse", p, 1);
        idle(17);
        check("prime.lat17", int'(bif.BPM_estimate), 0);
        idle(1);
        check_out("prime.lat18", 120, 1, 0);

        beat_gap(500, p);
        check("b1000.pulse", p, 1);
        idle(18);
        check_out("b1000", 120, 1, 0);

        // Edge inside the refractory window is ignored.
        idle(800 - since);
        beat_now(1'b0, p);
        check("refr.pulse", p, 0);
        idle(18);
        check("refr.bpm", int'(bif.BPM_estimate), 120);

        beat_gap(500, p);
        check("after_refr.pulse", p, 1);
        idle(18);
        check_out("after_refr", 120, 1, 0);

        // beat_in held high: a single accepted beat.
        idle(2000 - since);
        bif.beat_in = 1'b1;
        npulse = 0;
        since = -1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            since++;
            if (bif.beat_pulse) npulse++;
        end
        bif.beat_in = 1'b0;
        check("hold.pulses", npulse, 1);
        check("hold.bpm", int'(bif.BPM_estimate), 120);

        // Tracking and tempo step.
        prev = 120;
        for (int i = 0; i < 6; i++) begin
            beat_gap(vecs[i].gap_ms, p);
            check($sformatf("vec%0d.pulse", i), p, 1);
            idle(17);
            check($sformatf("vec%0d.lat17", i), int'(bif.BPM_estimate), prev);
            idle(1);
            check($sformatf("vec%0d.bpm", i), int'(bif.BPM_estimate), vecs[i].exp_bpm);
            check($sformatf("vec%0d.valid", i), bif.bpm_valid ? 1 : 0, 1);
            prev = vecs[i].exp_bpm;
        end

        // Beat-less timeout fires when interval_ms reaches 1500.
        idle(6000 - since);
        check_out("pre_timeout", 150, 1, 0);
        idle(1);
        check_out("timeout", 0, 0, 1);

        // Recovery: first beat only restarts timing, next beat primes and computes.
        idle(10);
        beat_now(1'b1, p);
        check("rec1.pulse", p, 1);
        check("rec1.timeout", bif.timeout ? 1 : 0, 0);
        idle(18);
        check_out("rec1", 0, 0, 0);
        beat_gap(301, p);
        check("rec2.pulse", p, 1);
        idle(18);
        check_out("rec2", 199, 1, 0);
        beat_gap(301, p);
        idle(18);
        check_out("rec3", 199, 1, 0);

        // Long interval: low clamp when the latest interval is used directly.
        beat_gap(1499, p);
        check("long.pulse", p, 1);
        idle(17);
        check("long.lat17", int'(bif.BPM_estimate), 199);
        idle(1);
        check_out("long", exp_low, 1, 0);

        // Reset in the middle of a division: no result may appear.
        beat_gap(400, p);
        idle(5);
        reset = 1'b0;
        idle(2);
        check_out("midreset", 0, 0, 0);
        check("midreset.pulse", bif.beat_pulse ? 1 : 0, 0);
        reset = 1'b1;
        idle(40);
        check_out("post_reset", 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
